// File: rtl/wb_uart_pkg.sv
// Shared constants for the Wishbone UART: register offsets (ADR[3:2]), STATUS bit
// positions and the TX/RX state encodings.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IEN    = 2'd3;

  localparam int ST_RXNE    = 0;
  localparam int ST_TXFULL  = 1;
  localparam int ST_TXEMPTY = 2;
  localparam int ST_RXOVR   = 3;
  localparam int ST_TXOVR   = 4;
  localparam int ST_FERR    = 5;
  localparam int ST_PERR    = 6;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
  } rx_state_e;

  // A 256-deep FIFO can hold 256 entries, which does not fit the 8-bit count field.
  function automatic logic [7:0] sat_count8(input logic [8:0] c);
    return (c > 9'd255) ? 8'hFF : c[7:0];
  endfunction

endpackage

// File: rtl/wb_uart_sync_fifo.sv
// Single-clock FIFO with an extra pointer bit to tell full from empty.
// Push on full and pop on empty are silently ignored.
module wb_uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_uart_fifo.sv
// Wishbone-slave 8N1 UART with TX/RX FIFOs, runtime baud divisor and maskable interrupt.
// Optional parity generation/checking is compiled in with `define UART_PARITY_EN.
module wb_uart_fifo
  import wb_uart_pkg::*;
#(
  parameter int          ADDRWIDTH          = 10,
  parameter int          FIFO_DEPTH         = 16,
  parameter logic [15:0] DEFAULT_DIVISOR    = 16'd7,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_n,
  input  logic [ADDRWIDTH-1:0] WBs_ADR,
  input  logic                 WBs_CYC,
  input  logic                 WBs_STB,
  input  logic                 WBs_WE,
  input  logic [3:0]           WBs_BYTE_STB,
  input  logic [31:0]          WBs_WR_DAT,
  output logic [31:0]          WBs_RD_DAT,
  output logic                 WBs_ACK,
  input  logic                 UART_SIN_i,
  output logic                 UART_SOUT_o,
  output logic                 UART_Intr_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_PARITY_EN
  localparam int IEN_W = 5;
`else
  localparam int IEN_W = 3;
`endif

  logic             r_ack, r_intr;
  logic [31:0]      r_rd_dat, w_rdata, w_status;
  logic [15:0]      r_div, r_tick_cnt, w_div_next;
  logic [IEN_W-1:0] r_ien;
  logic             r_rxovr, r_txovr, r_ferr, r_perr;
  logic             w_req, w_mapped, w_sel_data, w_sel_stat, w_sel_div, w_sel_ien;
  logic             w_tick, w_div_wr, w_stat_rd, w_txempty, w_err;
  logic             w_par_en, w_par_odd, w_unused;

  logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [7:0]       w_tx_dout;
  logic [CW-1:0]    w_tx_count;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]       w_rx_dout;
  logic [CW-1:0]    w_rx_count;

  tx_state_e        r_tx_state;
  logic [3:0]       r_tx_cnt;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx_par, r_sout, w_tx_bit_end;

  rx_state_e        r_rx_state;
  logic [3:0]       r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_pbad, r_sin_s1, r_sin_s2, r_sin_d, w_sin, w_rx_bit_end;
  logic             w_rx_stop_end, w_ferr_set, w_perr_set;

  assign w_unused = ^{WBs_ADR[1:0], WBs_BYTE_STB[3:2], WBs_WR_DAT[31:16], w_tx_count};

  // Bus decode: one ACK cycle per request, then a mandatory idle cycle.
  assign w_req      = WBs_CYC & WBs_STB & ~r_ack;
  assign w_mapped   = (WBs_ADR[ADDRWIDTH-1:4] == '0);
  assign w_sel_data = w_req & w_mapped & (WBs_ADR[3:2] == REG_DATA);
  assign w_sel_stat = w_req & w_mapped & (WBs_ADR[3:2] == REG_STATUS);
  assign w_sel_div  = w_req & w_mapped & (WBs_ADR[3:2] == REG_DIV);
  assign w_sel_ien  = w_req & w_mapped & (WBs_ADR[3:2] == REG_IEN);

  assign w_tx_push  = w_sel_data & WBs_WE & WBs_BYTE_STB[0];
  assign w_rx_pop   = w_sel_data & ~WBs_WE & ~w_rx_empty;
  assign w_stat_rd  = w_sel_stat & ~WBs_WE;
  assign w_div_wr   = w_sel_div & WBs_WE & (|WBs_BYTE_STB[1:0]);
  assign w_div_next = {WBs_BYTE_STB[1] ? WBs_WR_DAT[15:8] : r_div[15:8],
                       WBs_BYTE_STB[0] ? WBs_WR_DAT[7:0]  : r_div[7:0]};

`ifdef UART_PARITY_EN
  assign w_par_en   = r_ien[3];
  assign w_par_odd  = r_ien[4];
  assign w_perr_set = w_rx_stop_end & w_sin & r_rx_pbad;
`else
  assign w_par_en   = 1'b0;
  assign w_par_odd  = 1'b0;
  assign w_perr_set = 1'b0;
`endif

  assign w_txempty = w_tx_empty & (r_tx_state == TX_IDLE);
  assign w_err     = r_rxovr | r_txovr | r_ferr | r_perr;

  always_comb begin
    w_status                = '0;
    w_status[ST_RXNE]       = ~w_rx_empty;
    w_status[ST_TXFULL]     = w_tx_full;
    w_status[ST_TXEMPTY]    = w_txempty;
    w_status[ST_RXOVR]      = r_rxovr;
    w_status[ST_TXOVR]      = r_txovr;
    w_status[ST_FERR]       = r_ferr;
    w_status[ST_PERR]       = r_perr;
    w_status[15:8]          = sat_count8(9'(w_rx_count));
  end

  always_comb begin
    w_rdata = DEFAULT_READ_VALUE;
    if (w_mapped) begin
      case (WBs_ADR[3:2])
        REG_DATA:   w_rdata = w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
        REG_STATUS: w_rdata = w_status;
        REG_DIV:    w_rdata = {16'h0, r_div};
        default:    w_rdata = {{(32 - IEN_W){1'b0}}, r_ien};
      endcase
    end
  end

  // A flag raised in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_ack    <= 1'b0;
      r_rd_dat <= '0;
      r_div    <= DEFAULT_DIVISOR;
      r_ien    <= '0;
      r_rxovr  <= 1'b0;
      r_txovr  <= 1'b0;
      r_ferr   <= 1'b0;
      r_perr   <= 1'b0;
      r_intr   <= 1'b0;
    end else begin
      r_ack    <= w_req;
      r_rd_dat <= (w_req && !WBs_WE) ? w_rdata : 32'h0;
      if (w_div_wr) r_div <= w_div_next;
      if (w_sel_ien && WBs_WE && WBs_BYTE_STB[0]) r_ien <= WBs_WR_DAT[IEN_W-1:0];
      r_rxovr  <= (w_rx_push & w_rx_full) | (r_rxovr & ~w_stat_rd);
      r_txovr  <= (w_tx_push & w_tx_full) | (r_txovr & ~w_stat_rd);
      r_ferr   <= w_ferr_set | (r_ferr & ~w_stat_rd);
      r_perr   <= w_perr_set | (r_perr & ~w_stat_rd);
      r_intr   <= |(r_ien[2:0] & {w_err, w_txempty, ~w_rx_empty});
    end
  end

  assign WBs_ACK     = r_ack;
  assign WBs_RD_DAT  = r_rd_dat;
  assign UART_Intr_o = r_intr;
  assign UART_SOUT_o = r_sout;

  assign w_tick = (r_tick_cnt == 16'd0);

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n)            r_tick_cnt <= DEFAULT_DIVISOR;
    else if (w_div_wr)        r_tick_cnt <= w_div_next;
    else if (w_tick)          r_tick_cnt <= r_div;
    else                      r_tick_cnt <= r_tick_cnt - 16'd1;
  end

  wb_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(WB_CLK), .i_rst_n(WB_RST_n),
    .i_push(w_tx_push), .i_din(WBs_WR_DAT[7:0]), .i_pop(w_tx_pop),
    .o_dout(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  wb_uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(WB_CLK), .i_rst_n(WB_RST_n),
    .i_push(w_rx_push), .i_din(r_rx_shift), .i_pop(w_rx_pop),
    .o_dout(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  // Popping at the end of STOP chains frames without an idle bit between them.
  assign w_tx_bit_end = w_tick & (r_tx_cnt == 4'd15);
  assign w_tx_pop     = ~w_tx_empty &
                        ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_bit_end));

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_sout     <= 1'b1;
    end else begin
      if (w_tick && r_tx_state != TX_IDLE) r_tx_cnt <= r_tx_cnt + 4'd1;
      case (r_tx_state)
        TX_IDLE, TX_STOP: begin
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_dout;
            r_tx_par   <= (^w_tx_dout) ^ w_par_odd;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_sout     <= 1'b0;
            r_tx_state <= TX_START;
          end else if (r_tx_state == TX_STOP && w_tx_bit_end) begin
            r_tx_state <= TX_IDLE;
          end
        end
        TX_START: if (w_tx_bit_end) begin
          r_sout     <= r_tx_shift[0];
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_bit_end) begin
          if (r_tx_bit == 3'd7) begin
            r_sout     <= w_par_en ? r_tx_par : 1'b1;
            r_tx_state <= w_par_en ? TX_PARITY : TX_STOP;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= r_tx_shift >> 1;
            r_sout     <= r_tx_shift[1];
          end
        end
        TX_PARITY: if (w_tx_bit_end) begin
          r_sout     <= 1'b1;
          r_tx_state <= TX_STOP;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign w_sin         = r_sin_s2;
  assign w_rx_bit_end  = w_tick & (r_rx_cnt == 4'd15);
  assign w_rx_stop_end = (r_rx_state == RX_STOP) & w_rx_bit_end;
  assign w_ferr_set    = w_rx_stop_end & ~w_sin;
  assign w_rx_push     = w_rx_stop_end & w_sin & ~r_rx_pbad;

  // START is checked at tick 8; every later bit is sampled 16 ticks on, i.e. mid-bit.
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_sin_s1   <= 1'b1;
      r_sin_s2   <= 1'b1;
      r_sin_d    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_pbad  <= 1'b0;
    end else begin
      r_sin_s1 <= UART_SIN_i;
      r_sin_s2 <= r_sin_s1;
      r_sin_d  <= r_sin_s2;
      if (w_tick) r_rx_cnt <= r_rx_cnt + 4'd1;
      case (r_rx_state)
        RX_IDLE: if (r_sin_d && !w_sin) begin
          r_rx_cnt   <= '0;
          r_rx_state <= RX_START;
        end
        RX_START: if (w_tick && r_rx_cnt == 4'd7) begin
          r_rx_cnt   <= '0;
          r_rx_bit   <= '0;
          r_rx_state <= w_sin ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (w_rx_bit_end) begin
          r_rx_shift <= {w_sin, r_rx_shift[7:1]};
          r_rx_bit   <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) begin
            r_rx_pbad  <= 1'b0;
            r_rx_state <= w_par_en ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (w_rx_bit_end) begin
          r_rx_pbad  <= w_sin ^ (^r_rx_shift) ^ w_par_odd;
          r_rx_state <= RX_STOP;
        end
        RX_STOP: if (w_rx_bit_end) r_rx_state <= w_sin ? RX_IDLE : RX_BREAK;
        RX_BREAK: if (w_sin) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_uart_fifo.sv
// Directed bench for wb_uart_fifo: register map, TX framing, loopback, overflow,
// RX error handling, parity (when UART_PARITY_EN is defined) and reset abort.
module tb_wb_uart_fifo;

  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] A_DATA = 10'h000;
  localparam logic [AW-1:0] A_STAT = 10'h004;
  localparam logic [AW-1:0] A_DIV  = 10'h008;
  localparam logic [AW-1:0] A_IEN  = 10'h00C;
  localparam logic [AW-1:0] A_UNM  = 10'h010;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] adr = '0;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]    be = 4'h0;
  logic [31:0]   wdat = '0;
  logic [31:0]   rdat;
  logic          ack, sout, intr, sin;
  logic          r_loop = 1'b0;
  logic          r_sin_drv = 1'b1;
  logic          r_count_falls = 1'b0;
  int            n_falls = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic [31:0]   exp_q[$];

  always #5 clk = ~clk;
  assign sin = r_loop ? sout : r_sin_drv;
  always @(negedge sout) if (r_count_falls) n_falls++;

  wb_uart_fifo #(.ADDRWIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .WB_CLK(clk), .WB_RST_n(rst_n), .WBs_ADR(adr), .WBs_CYC(cyc), .WBs_STB(stb),
    .WBs_WE(we), .WBs_BYTE_STB(be), .WBs_WR_DAT(wdat), .WBs_RD_DAT(rdat),
    .WBs_ACK(ack), .UART_SIN_i(sin), .UART_SOUT_o(sout), .UART_Intr_o(intr)
  );

  // Valid/ready: a request is held from a negedge until ACK is seen one cycle after
  // the request edge; read data is taken in the ACK cycle and the request dropped.
  task automatic wb_access(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] q);
    logic got;
    got = 1'b0;
    q = '0;
    @(negedge clk);
    adr = a; we = w; wdat = d; be = b; cyc = 1'b1; stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        got = 1'b1;
        q = rdat;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL wb_ack_timeout adr=%h got no ACK, required ACK within 8 cycles", a);
    end
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] q;
    wb_access(a, 1'b1, d, b, q);
  endtask

  task automatic wb_read(input logic [AW-1:0] a, output logic [31:0] q);
    wb_access(a, 1'b0, 32'h0, 4'hF, q);
  endtask

  task automatic drive_bit(input logic b);
    r_sin_drv = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                             input logic stop_bit);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (with_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    r_sin_drv = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] q;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_tests++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %b want 0", ack); end
    n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL rst_sout got %b want 1", sout); end
    n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL rst_intr got %b want 0", intr); end
    n_tests++; if (rdat !== 32'h0) begin n_fail++; $display("FAIL rst_rdat got %h want 0", rdat); end
    @(negedge clk); rst_n = 1'b1;
    wb_read(A_STAT, q);
    n_tests++; if (q !== 32'h4) begin n_fail++; $display("FAIL rst_status got %h want 00000004", q); end
    wb_read(A_DIV, q);
    n_tests++; if (q !== 32'h7) begin n_fail++; $display("FAIL rst_div got %h want 00000007", q); end
    wb_read(A_UNM, q);
    n_tests++; if (q !== 32'hBADFABAC) begin n_fail++; $display("FAIL unmapped got %h want badfabac", q); end
    wb_read(A_IEN, q);
    n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL rst_ien got %h want 0", q); end
    wb_read(A_DATA, q);
    n_tests++; if (q !== 32'h0) begin n_fail++; $display("FAIL empty_rx_read got %h want 0", q); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] q;
    wb_write(A_DIV, 32'h0000_1234, 4'b0001);
    wb_read(A_DIV, q);
    n_tests++; if (q !== 32'h34) begin n_fail++; $display("FAIL div_be0 got %h want 00000034", q); end
    wb_write(A_DIV, 32'h0000_AB00, 4'b0010);
    wb_read(A_DIV, q);
    n_tests++; if (q !== 32'hAB34) begin n_fail++; $display("FAIL div_be1 got %h want 0000ab34", q); end
    wb_write(A_DATA, 32'h11, 4'b1110);
    repeat (3) @(posedge clk);
    wb_read(A_STAT, q);
    n_tests++; if (q !== 32'h4) begin n_fail++; $display("FAIL data_no_be0 got %h want 00000004", q); end
  endtask

  task automatic test_tx_frame();
    logic [31:0] q;
    logic [9:0]  exp_bits;
    int          t;
    wb_write(A_DIV, 32'h0, 4'hF);
    wb_write(A_DATA, 32'h55, 4'hF);
    t = 0;
    while (sout !== 1'b0 && t < 20) begin @(posedge clk); #1; t++; end
    n_tests++; if (sout !== 1'b0) begin n_fail++; $display("FAIL tx_start_edge got %b want 0", sout); end
    exp_bits = {1'b1, 8'h55, 1'b0};
    repeat (8) @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (sout !== exp_bits[i]) begin
        n_fail++; $display("FAIL tx_bit%0d got %b want %b", i, sout, exp_bits[i]);
      end
      if (i < 9) begin repeat (16) @(posedge clk); #1; end
    end
    wb_read(A_STAT, q);
    n_tests++; if (q[2] !== 1'b0) begin n_fail++; $display("FAIL tx_busy_in_stop got %b want 0", q[2]); end
    repeat (8) @(posedge clk);
    wb_read(A_STAT, q);
    n_tests++; if (q[2] !== 1'b1) begin n_fail++; $display("FAIL tx_empty_after got %b want 1", q[2]); end
  endtask

  task automatic test_loopback();
    logic [31:0] q, e;
    logic [7:0]  prev;
    int          waited;
    r_loop = 1'b1;
    wb_write(A_IEN, 32'h1, 4'hF);
    exp_q.push_back(32'hA3); exp_q.push_back(32'h00); exp_q.push_back(32'hFF);
    foreach (exp_q[i]) wb_write(A_DATA, exp_q[i], 4'hF);
    prev = 8'd0;
    for (int k = 1; k <= 3; k++) begin
      waited = 0;
      do begin wb_read(A_STAT, q); waited++; end while (q[15:8] == prev && waited < 400);
      n_tests++;
      if (q[15:8] !== 8'(k)) begin n_fail++; $display("FAIL rx_count_step got %0d want %0d", q[15:8], k); end
      prev = q[15:8];
    end
    @(posedge clk); #1;
    n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL rxne_intr got %b want 1", intr); end
    for (int k = 0; k < 3; k++) begin
      wb_read(A_DATA, q);
      e = exp_q.pop_front();
      n_tests++; if (q !== e) begin n_fail++; $display("FAIL loop_byte%0d got %h want %h", k, q, e); end
      n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL intr_held%0d got %b want 1", k, intr); end
    end
    @(posedge clk); #1;
    n_tests++; if (intr !== 1'b0) begin n_fail++; $display("FAIL intr_after_drain got %b want 0", intr); end
    wb_write(A_IEN, 32'h0, 4'hF);
    r_loop = 1'b0;
  endtask

  task automatic test_txovr();
    logic [31:0] q;
    int          waited;
    wb_write(A_DIV, 32'h2, 4'hF);
    n_falls = 0;
    r_count_falls = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) wb_write(A_DATA, 32'hFF, 4'hF);
    wb_read(A_STAT, q);
    n_tests++; if (q[4] !== 1'b1) begin n_fail++; $display("FAIL txovr_set got %b want 1", q[4]); end
    n_tests++; if (q[1] !== 1'b1) begin n_fail++; $display("FAIL txfull got %b want 1", q[1]); end
    wb_read(A_STAT, q);
    n_tests++; if (q[4] !== 1'b0) begin n_fail++; $display("FAIL txovr_clear got %b want 0", q[4]); end
    waited = 0;
    do begin repeat (20) @(posedge clk); wb_read(A_STAT, q); waited++; end
    while (q[2] !== 1'b1 && waited < 200);
    n_tests++; if (q[2] !== 1'b1) begin n_fail++; $display("FAIL txovr_drain got %b want 1", q[2]); end
    r_count_falls = 1'b0;
    n_tests++;
    if (n_falls != DEPTH + 1) begin n_fail++; $display("FAIL txovr_frames got %0d want %0d", n_falls, DEPTH + 1); end
  endtask

  task automatic test_rx_errors();
    logic [31:0] q;
    wb_write(A_DIV, 32'h0, 4'hF);
    drive_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    wb_read(A_STAT, q);
    n_tests++; if (q[5] !== 1'b1) begin n_fail++; $display("FAIL ferr_set got %b want 1", q[5]); end
    n_tests++; if (q[15:8] !== 8'd0) begin n_fail++; $display("FAIL ferr_count got %0d want 0", q[15:8]); end
    wb_read(A_STAT, q);
    n_tests++; if (q[5] !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b want 0", q[5]); end
    @(negedge clk); r_sin_drv = 1'b0;
    repeat (4) @(negedge clk); r_sin_drv = 1'b1;
    repeat (60) @(negedge clk);
    wb_read(A_STAT, q);
    n_tests++; if (q[15:0] !== 16'h0004) begin n_fail++; $display("FAIL glitch_status got %h want 0004", q[15:0]); end
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    wb_read(A_DATA, q);
    n_tests++; if (q !== 32'h3C) begin n_fail++; $display("FAIL rx_after_errs got %h want 0000003c", q); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [31:0] q;
    wb_write(A_IEN, 32'h0C, 4'hF);
    drive_frame(8'h07, 1'b1, 1'b0, 1'b1);
    n_tests++; if (intr !== 1'b1) begin n_fail++; $display("FAIL perr_intr got %b want 1", intr); end
    wb_read(A_STAT, q);
    n_tests++; if (q[6] !== 1'b1) begin n_fail++; $display("FAIL perr_set got %b want 1", q[6]); end
    n_tests++; if (q[15:8] !== 8'd0) begin n_fail++; $display("FAIL perr_drop got %0d want 0", q[15:8]); end
    drive_frame(8'h07, 1'b1, 1'b1, 1'b1);
    wb_read(A_DATA, q);
    n_tests++; if (q !== 32'h07) begin n_fail++; $display("FAIL par_good got %h want 00000007", q); end
    wb_write(A_IEN, 32'h0, 4'hF);
  endtask
`else
  task automatic test_parity();
    logic [31:0] q;
    wb_write(A_IEN, 32'h1F, 4'hF);
    wb_read(A_IEN, q);
    n_tests++; if (q !== 32'h07) begin n_fail++; $display("FAIL ien_width got %h want 00000007", q); end
    wb_write(A_IEN, 32'h0, 4'hF);
    wb_read(A_STAT, q);
    n_tests++; if (q[6] !== 1'b0) begin n_fail++; $display("FAIL perr_absent got %b want 0", q[6]); end
  endtask
`endif

  task automatic test_reset_abort();
    logic [31:0] q;
    wb_write(A_DIV, 32'h0, 4'hF);
    wb_write(A_DATA, 32'h00, 4'hF);
    repeat (40) @(posedge clk); #1;
    n_tests++; if (sout !== 1'b0) begin n_fail++; $display("FAIL abort_midframe got %b want 0", sout); end
    #3 rst_n = 1'b0;
    #1;
    n_tests++; if (sout !== 1'b1) begin n_fail++; $display("FAIL abort_sout got %b want 1", sout); end
    @(negedge clk); rst_n = 1'b1;
    wb_read(A_DIV, q);
    n_tests++; if (q !== 32'h7) begin n_fail++; $display("FAIL abort_div got %h want 00000007", q); end
    wb_read(A_STAT, q);
    n_tests++; if (q !== 32'h4) begin n_fail++; $display("FAIL abort_status got %h want 00000004", q); end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_tx_frame();
    test_loopback();
    test_txovr();
    test_rx_errors();
    test_parity();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
